// File: rtl/boreal_dma_pkg.sv
// Shared definitions for the DMA tile mover: FSM encoding, job modes and
// the width of the per-port retry counters.
package boreal_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // Retry counters are sized for any MAX_RETRY up to 2^RETRY_W - 1.
    localparam int RETRY_W = 16;

endpackage

// File: rtl/boreal_dma_port_ctl.sv
// Per-port access controller: drives the one-cycle request, samples the
// acknowledge in the wait cycle and counts unacknowledged attempts.
// Handshake: sel is high for exactly the request cycle; the slave answers
// with ack in the following (wait) cycle, otherwise the attempt is retried.
module boreal_dma_port_ctl
    import boreal_dma_pkg::*;
#(
    parameter int MAX_RETRY = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,     // a job is running; counter is held clear otherwise
    input  logic req,        // FSM is in this port's request state
    input  logic wait_st,    // FSM is in this port's wait state
    input  logic ack,
    output logic sel,
    output logic acked,      // access completed this cycle
    output logic retry_exp   // this unacknowledged attempt exhausts the budget
);

    logic [RETRY_W-1:0] retry_cnt;

    assign sel       = req;
    assign acked     = wait_st & ack;
    assign retry_exp = wait_st & ~ack & ((32'(retry_cnt) + 32'd1) >= 32'(MAX_RETRY));

    // Count failed attempts of the current access; any ack starts afresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (!active || acked) begin
            retry_cnt <= '0;
        end else if (wait_st) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end

endmodule

// File: rtl/boreal_dma_tile_mover.sv
// DMA tile mover: copies a block of words from the source port to the
// destination port, or fills the destination with a constant. One access
// is outstanding at a time and the two ports are never active together.
module boreal_dma_tile_mover
    import boreal_dma_pkg::*;
#(
    parameter int DEPTH_LOG = 10,
    parameter int MAX_RETRY = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode,
    input  logic [DEPTH_LOG-1:0] src_addr,
    input  logic [DEPTH_LOG-1:0] dst_addr,
    input  logic [DEPTH_LOG:0]   len,
    input  logic [31:0]          fill_data,
    output logic                 src_sel,
    output logic                 src_wr,
    output logic [DEPTH_LOG-1:0] src_addr_o,
    output logic [31:0]          src_wdata,
    input  logic [31:0]          src_rdata,
    input  logic                 src_ack,
    output logic                 dst_sel,
    output logic                 dst_wr,
    output logic [DEPTH_LOG-1:0] dst_addr_o,
    output logic [31:0]          dst_wdata,
    input  logic [31:0]          dst_rdata,
    input  logic                 dst_ack,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [DEPTH_LOG:0]   words_done,
    output logic [2:0]           state_dbg
);

    state_t               state_q, state_d;
    logic                 mode_q;
    logic [DEPTH_LOG-1:0] src_q, dst_q;
    logic [DEPTH_LOG:0]   len_q, index_q;
    logic [31:0]          fill_q, data_q;
    logic                 err_q;
    logic                 src_acked, src_exp, dst_acked, dst_exp;
    logic                 last_word;
    logic                 unused_dst_rdata;

    // Destination read data carries nothing for a write-only port.
    assign unused_dst_rdata = ^dst_rdata;

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign words_done = index_q;
    assign state_dbg = state_q;
    assign last_word = ((index_q + (DEPTH_LOG+1)'(1)) == len_q);

    // Addresses wrap naturally in DEPTH_LOG bits; outputs idle at zero.
    assign src_wr     = 1'b0;
    assign src_wdata  = '0;
    assign src_addr_o = src_sel ? (src_q + index_q[DEPTH_LOG-1:0]) : '0;
    assign dst_wr     = dst_sel;
    assign dst_addr_o = dst_sel ? (dst_q + index_q[DEPTH_LOG-1:0]) : '0;
    assign dst_wdata  = dst_sel ? ((mode_q == MODE_FILL) ? fill_q : data_q) : '0;

    boreal_dma_port_ctl #(.MAX_RETRY(MAX_RETRY)) u_src_ctl (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (busy),
        .req       (state_q == ST_RD_REQ),
        .wait_st   (state_q == ST_RD_WAIT),
        .ack       (src_ack),
        .sel       (src_sel),
        .acked     (src_acked),
        .retry_exp (src_exp)
    );

    boreal_dma_port_ctl #(.MAX_RETRY(MAX_RETRY)) u_dst_ctl (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (busy),
        .req       (state_q == ST_WR_REQ),
        .wait_st   (state_q == ST_WR_WAIT),
        .ack       (dst_ack),
        .sel       (dst_sel),
        .acked     (dst_acked),
        .retry_exp (dst_exp)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort overrides every transition of an active job.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0)              state_d = ST_DONE;
                    else if (mode == MODE_FILL) state_d = ST_WR_REQ;
                    else                        state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (src_acked)    state_d = ST_WR_REQ;
                else if (src_exp) state_d = ST_DONE;
                else              state_d = ST_RD_REQ;
            end
            ST_WR_REQ:  state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (dst_acked) begin
                    if (last_word)              state_d = ST_DONE;
                    else if (mode_q == MODE_FILL) state_d = ST_WR_REQ;
                    else                        state_d = ST_RD_REQ;
                end else if (dst_exp) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WR_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (busy && abort) state_d = ST_DONE;
    end

    // Job registers: latch config on start, capture read data, count words,
    // and record failure. An aborted cycle discards any ack it carries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            index_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                mode_q  <= mode;
                src_q   <= src_addr;
                dst_q   <= dst_addr;
                len_q   <= len;
                fill_q  <= fill_data;
                index_q <= '0;
                err_q   <= 1'b0;
            end
            if (busy && abort) begin
                err_q <= 1'b1;
            end else begin
                if (src_acked)          data_q  <= src_rdata;
                if (dst_acked)          index_q <= index_q + (DEPTH_LOG+1)'(1);
                if (src_exp || dst_exp) err_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_boreal_dma_tile_mover.sv
// Bench for the DMA tile mover: a registered memory slave answers one cycle
// after each request and can refuse a programmable number of requests; a
// word-level model predicts the write sequence and the completion cycle.
module tb_boreal_dma_tile_mover;

    localparam int DL = 10;
    localparam int N  = 1 << DL;
    localparam int B_MAX_RETRY = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Stimulus
    logic          start, abort, mode, b_start;
    logic [DL-1:0] src_addr, dst_addr;
    logic [DL:0]   len;
    logic [31:0]   fill_data;
    logic [31:0]   dst_rdata;

    // Instance A (default parameters)
    logic          src_sel, src_wr, src_ack, dst_sel, dst_wr, dst_ack;
    logic [DL-1:0] src_addr_o, dst_addr_o;
    logic [31:0]   src_wdata, src_rdata, dst_wdata;
    logic          busy, done, err;
    logic [DL:0]   words_done;
    logic [2:0]    state_dbg;

    // Instance B (small retry budget, destination never acknowledges)
    logic          b_src_sel, b_src_wr, b_dst_sel, b_dst_wr;
    logic [DL-1:0] b_src_addr_o, b_dst_addr_o;
    logic [31:0]   b_src_wdata, b_dst_wdata;
    logic          b_busy, b_done, b_err;
    logic [DL:0]   b_words_done;
    logic [2:0]    b_state_dbg;

    boreal_dma_tile_mover u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
        .src_sel(src_sel), .src_wr(src_wr), .src_addr_o(src_addr_o), .src_wdata(src_wdata),
        .src_rdata(src_rdata), .src_ack(src_ack),
        .dst_sel(dst_sel), .dst_wr(dst_wr), .dst_addr_o(dst_addr_o), .dst_wdata(dst_wdata),
        .dst_rdata(dst_rdata), .dst_ack(dst_ack),
        .busy(busy), .done(done), .err(err), .words_done(words_done), .state_dbg(state_dbg)
    );

    boreal_dma_tile_mover #(.DEPTH_LOG(DL), .MAX_RETRY(B_MAX_RETRY)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(abort), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
        .src_sel(b_src_sel), .src_wr(b_src_wr), .src_addr_o(b_src_addr_o), .src_wdata(b_src_wdata),
        .src_rdata(32'h0), .src_ack(1'b0),
        .dst_sel(b_dst_sel), .dst_wr(b_dst_wr), .dst_addr_o(b_dst_addr_o), .dst_wdata(b_dst_wdata),
        .dst_rdata(dst_rdata), .dst_ack(1'b0),
        .busy(b_busy), .done(b_done), .err(b_err), .words_done(b_words_done), .state_dbg(b_state_dbg)
    );

    int tests = 0;
    int fails = 0;
    int viol  = 0;

    // Memory slave state
    logic [31:0] src_mem [N];
    logic        bus_clr;
    int          src_refuse, dst_refuse;
    int          src_n, dst_n;
    logic [DL+31:0] wr_log [$];

    // Registered slave: answers the cycle after a request unless refusing.
    always @(posedge clk) begin
        if (bus_clr) begin
            src_n   <= 0;
            dst_n   <= 0;
            src_ack <= 1'b0;
            dst_ack <= 1'b0;
            wr_log.delete();
        end else begin
            src_ack   <= 1'b0;
            dst_ack   <= 1'b0;
            src_rdata <= $urandom;
            if (src_sel) begin
                if (src_n < src_refuse) src_n <= src_n + 1;
                else begin
                    src_ack   <= 1'b1;
                    src_rdata <= src_mem[src_addr_o];
                end
            end
            if (dst_sel && dst_wr) begin
                if (dst_n < dst_refuse) dst_n <= dst_n + 1;
                else begin
                    dst_ack <= 1'b1;
                    wr_log.push_back({dst_addr_o, dst_wdata});
                end
            end
        end
    end

    // Bus rule monitor on both instances.
    logic prev_src = 1'b0, prev_dst = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (src_sel && dst_sel) viol <= viol + 1;
            if (src_sel && prev_src) viol <= viol + 1;
            if (dst_sel && prev_dst) viol <= viol + 1;
            if (!src_sel && src_addr_o != '0) viol <= viol + 1;
            if (!dst_sel && (dst_wr || dst_addr_o != '0 || dst_wdata != '0)) viol <= viol + 1;
            if (src_wr || src_wdata != '0) viol <= viol + 1;
            if (b_src_sel || b_src_wr || b_src_addr_o != '0 || b_src_wdata != '0) viol <= viol + 1;
            if (!b_dst_sel && (b_dst_wr || b_dst_addr_o != '0 || b_dst_wdata != '0)) viol <= viol + 1;
        end
        prev_src <= src_sel;
        prev_dst <= dst_sel;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, 64'({src_sel, src_wr, src_addr_o, dst_sel, dst_wr, dst_addr_o,
                                busy, done, err, words_done}), 64'h0);
        chk({tag, "_data"}, {src_wdata, dst_wdata}, 64'h0);
    endtask

    task automatic clear_bus(input int sref, input int dref);
        @(negedge clk);
        bus_clr    = 1'b1;
        src_refuse = sref;
        dst_refuse = dref;
        @(negedge clk);
        bus_clr    = 1'b0;
    endtask

    // Run one job on instance A and score it against the word-level model.
    task automatic run_job(input logic m, input logic [DL-1:0] s, input logic [DL-1:0] d,
                           input logic [DL:0] l, input logic [31:0] f,
                           input int sref, input int dref, input bit poke);
        logic [DL+31:0] exp_q [$];
        logic [DL-1:0]  a, sa;
        logic [DL+31:0] got;
        int cyc, exp_cyc;
        for (int i = 0; i < int'(l); i++) begin
            a  = d + DL'(i);
            sa = s + DL'(i);
            exp_q.push_back({a, (m == 1'b1) ? f : src_mem[sa]});
        end
        exp_cyc = (l == '0) ? 1 : 1 + int'(l) * ((m == 1'b1) ? 2 : 4) + 2 * (sref + dref);

        clear_bus(sref, dref);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Config must have been latched; scramble it for the rest of the job.
        mode = 1'($urandom); src_addr = DL'($urandom); dst_addr = DL'($urandom);
        len = (DL+1)'($urandom); fill_data = $urandom;
        cyc = 1;
        while (!done && cyc < 3000) begin
            if (poke && cyc == 3) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk("done_cycle", 64'(cyc), 64'(exp_cyc));
        chk("words_done", 64'(words_done), 64'(l));
        chk("err_clear", 64'(err), 64'h0);
        chk("busy_at_done", 64'(busy), 64'h0);
        chk("wr_count", 64'(wr_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_log.size()) ? wr_log[i] : 'x;
            chk("wr_entry", 64'(got), 64'(exp_q[i]));
        end
        @(posedge clk); #1;
        chk("done_pulse", 64'({done, busy}), 64'h0);
    endtask

    initial begin
        int cyc, sel_seen;
        logic          rm;
        logic [DL-1:0] rs, rd;
        logic [DL:0]   rl;
        int            sr, dr;

        rst_n = 1'b0; bus_clr = 1'b1; start = 1'b0; b_start = 1'b0; abort = 1'b0;
        mode = 1'b0; src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
        dst_rdata = $urandom; src_refuse = 0; dst_refuse = 0;
        for (int i = 0; i < N; i++) src_mem[i] = $urandom;

        repeat (3) @(posedge clk);
        #1 chk_quiet("reset");
        @(negedge clk) rst_n = 1'b1;

        // Plain copy and wrapping fill.
        run_job(1'b0, 10'h010, 10'h200, 11'd4, 32'h0, 0, 0, 1'b0);
        run_job(1'b1, 10'h123, 10'h3FE, 11'd3, 32'hA5A5A5A5, 0, 0, 1'b0);

        // Five refused source requests before the read is accepted.
        run_job(1'b0, 10'h0AB, 10'h0CD, 11'd1, 32'h0, 5, 0, 1'b0);

        // Retry exhaustion on instance B: destination never acknowledges.
        mode = 1'b1; dst_addr = 10'h055; len = 11'd2; fill_data = 32'h12345678;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        cyc = 1;
        while (!b_done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("retry_done_cycle", 64'(cyc), 64'(1 + 2 * B_MAX_RETRY));
        chk("retry_err", 64'(b_err), 64'h1);
        chk("retry_words", 64'(b_words_done), 64'h0);
        sel_seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (b_dst_sel || b_busy) sel_seen++;
        end
        chk("retry_quiet_after", 64'(sel_seen), 64'h0);
        chk("retry_err_sticky", 64'(b_err), 64'h1);

        // Abort in the write-wait cycle of the second word.
        clear_bus(0, 0);
        mode = 1'b0; src_addr = 10'h300; dst_addr = 10'h100; len = 11'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_pre_words", 64'(words_done), 64'h1);
        chk("abort_pre_busy", 64'({busy, src_sel, dst_sel}), 64'h4);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_sel", 64'({src_sel, dst_sel}), 64'h0);
        chk("abort_done", 64'({done, err, busy}), 64'h6);
        chk("abort_words", 64'(words_done), 64'h1);
        @(posedge clk); #1;
        chk("abort_after", 64'({done, err, busy, src_sel, dst_sel}), 64'h8);

        // Reset during a read wait, then an empty job.
        clear_bus(0, 0);
        mode = 1'b0; src_addr = 10'h010; dst_addr = 10'h020; len = 11'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 chk_quiet("rst_mid_job");
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_no_done", 64'({done, busy, src_sel, dst_sel}), 64'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        run_job(1'b0, 10'h3FF, 10'h3FF, 11'd0, 32'h0, 0, 0, 1'b0);

        // Randomised jobs against the model.
        for (int k = 0; k < 12; k++) begin
            rm = 1'($urandom_range(0, 1));
            rs = DL'($urandom);
            rd = DL'($urandom);
            rl = (DL+1)'($urandom_range(0, 24));
            sr = (rl != '0 && rm == 1'b0) ? int'($urandom_range(0, 3)) : 0;
            dr = (rl != '0) ? int'($urandom_range(0, 3)) : 0;
            run_job(rm, rs, rd, rl, $urandom, sr, dr, (k % 3 == 0) && (rl >= 2));
        end

        // Full-depth fill covering every address once.
        run_job(1'b1, 10'h000, DL'($urandom), 11'd1024, $urandom, 0, 0, 1'b0);

        chk("protocol", 64'(viol), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
